ram_arbiter: RTL

Two-client front end that sits directly upstream of the single-port synchronous RAM. Each client (A, B) issues one read or write request at a time. The block arbitrates round-robin and drives the RAM's read/write strobes, address and data for one cycle. It then waits for the RAM's done pulse and returns completion (and read data) to the owning client. It is the only master on the RAM port.

---
 rtl/ram_arbiter_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 32 +++
 rtl/ram_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the two-client RAM arbiter and its round-robin picker.
package ram_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } state_e;

   typedef enum logic {
      OwnerA,
      OwnerB
   } owner_e;

   localparam int unsigned DefaultTimeoutCycles = 15;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker; on a tie the client not granted last time wins.
module rr_arbiter2
   import ram_arbiter_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_req_a,
   input  logic i_req_b,
   output logic o_gnt_a,
   output logic o_gnt_b
);

   owner_e last_q;

   always_comb begin
      o_gnt_a = i_en & i_req_a & (~i_req_b | (last_q == OwnerB));
      o_gnt_b = i_en & i_req_b & (~i_req_a | (last_q == OwnerA));
   end

   // Reset to B so that A wins the first tie.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_q <= OwnerB;
      end else if (o_gnt_a) begin
         last_q <= OwnerA;
      end else if (o_gnt_b) begin
         last_q <= OwnerB;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Two-client round-robin front end for a single-port synchronous RAM.
// Optional WAIT timeout/abort enabled by defining RAM_ARBITER_TIMEOUT_EN.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_a_req,
   input  logic                  i_a_we,
   input  logic [ADDR_WIDTH-1:0] i_a_addr,
   input  logic [DATA_WIDTH-1:0] i_a_wdata,
   output logic                  o_a_gnt,
   output logic                  o_a_done,
   output logic [DATA_WIDTH-1:0] o_a_rdata,
   input  logic                  i_b_req,
   input  logic                  i_b_we,
   input  logic [ADDR_WIDTH-1:0] i_b_addr,
   input  logic [DATA_WIDTH-1:0] i_b_wdata,
   output logic                  o_b_gnt,
   output logic                  o_b_done,
   output logic [DATA_WIDTH-1:0] o_b_rdata,
   output logic                  o_err,
   output logic                  o_ram_read,
   output logic                  o_ram_write,
   output logic [ADDR_WIDTH-1:0] o_ram_address,
   output logic [DATA_WIDTH-1:0] o_ram_data,
   input  logic                  i_ram_done,
   input  logic [DATA_WIDTH-1:0] i_ram_data
);

   state_e                state_q, state_d;
   owner_e                owner_q, owner_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic                  gnt_a, gnt_b;
   logic                  done_ok, timeout, finish;
   logic                  a_gnt_d, b_gnt_d, a_done_d, b_done_d;
   logic                  ram_read_d, ram_write_d;
   logic [ADDR_WIDTH-1:0] ram_address_d;
   logic [DATA_WIDTH-1:0] ram_data_d, a_rdata_d, b_rdata_d;

   rr_arbiter2 u_rr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (state_q == StIdle),
      .i_req_a (i_a_req),
      .i_req_b (i_b_req),
      .o_gnt_a (gnt_a),
      .o_gnt_b (gnt_b)
   );

   // WAIT begins on the strobe cycle; a done there cannot belong to this op.
   assign done_ok = (state_q == StWait) & i_ram_done & ~(o_ram_read | o_ram_write);
   assign finish  = done_ok | timeout;

`ifdef RAM_ARBITER_TIMEOUT_EN
   localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntWidth-1:0] wait_cnt_q;

   assign timeout = (state_q == StWait) & ~done_ok &
                    (wait_cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wait_cnt_q <= '0;
         o_err      <= 1'b0;
      end else begin
         wait_cnt_q <= (state_q == StWait) ? wait_cnt_q + CntWidth'(1) : '0;
         o_err      <= timeout;
      end
   end
`else
   assign timeout = 1'b0;
   assign o_err   = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q       <= StIdle;
         owner_q       <= OwnerA;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         o_a_gnt       <= 1'b0;
         o_b_gnt       <= 1'b0;
         o_a_done      <= 1'b0;
         o_b_done      <= 1'b0;
         o_a_rdata     <= '0;
         o_b_rdata     <= '0;
         o_ram_read    <= 1'b0;
         o_ram_write   <= 1'b0;
         o_ram_address <= '0;
         o_ram_data    <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         o_a_gnt       <= a_gnt_d;
         o_b_gnt       <= b_gnt_d;
         o_a_done      <= a_done_d;
         o_b_done      <= b_done_d;
         o_a_rdata     <= a_rdata_d;
         o_b_rdata     <= b_rdata_d;
         o_ram_read    <= ram_read_d;
         o_ram_write   <= ram_write_d;
         o_ram_address <= ram_address_d;
         o_ram_data    <= ram_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         StIdle: begin
            if (gnt_a) begin
               state_d = StIssue;
               owner_d = OwnerA;
               we_d    = i_a_we;
               addr_d  = i_a_addr;
               wdata_d = i_a_wdata;
            end else if (gnt_b) begin
               state_d = StIssue;
               owner_d = OwnerB;
               we_d    = i_b_we;
               addr_d  = i_b_addr;
               wdata_d = i_b_wdata;
            end
         end
         StIssue: state_d = StWait;
         StWait:  if (finish) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      a_gnt_d       = gnt_a;
      b_gnt_d       = gnt_b;
      ram_read_d    = (state_q == StIssue) & ~we_q;
      ram_write_d   = (state_q == StIssue) & we_q;
      ram_address_d = (state_q == StIssue) ? addr_q : o_ram_address;
      ram_data_d    = (state_q == StIssue) ? wdata_q : o_ram_data;
      a_done_d      = finish & (owner_q == OwnerA);
      b_done_d      = finish & (owner_q == OwnerB);
      // Read data only moves on a genuine read completion; aborts keep the old value.
      a_rdata_d     = (done_ok & ~we_q & (owner_q == OwnerA)) ? i_ram_data : o_a_rdata;
      b_rdata_d     = (done_ok & ~we_q & (owner_q == OwnerB)) ? i_ram_data : o_b_rdata;
   end

endmodule
